// File: rtl/traffic_intersection_model.sv
// Intersection model: per-lane car queues drained on green feed sensors back to the controller,
// with sticky checks for conflicting lights, illegal colour sequences and queue overflow.
module traffic_intersection_model #(
   parameter int Q_W    = 4,
   parameter int WAIT_W = 8,
   parameter int SRV_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        arrive,
   input  logic [1:0]        e_left_light,
   input  logic [1:0]        e_str_light,
   input  logic [1:0]        w_left_light,
   input  logic [1:0]        w_str_light,
   input  logic [1:0]        ns_light,
   output logic              e_left_sensor,
   output logic              e_str_sensor,
   output logic              w_left_sensor,
   output logic              w_str_sensor,
   output logic              ns_sensor,
   output logic              conflict_err,
   output logic              seq_err,
   output logic              ovf_err,
   output logic [SRV_W-1:0]  served_cnt,
   output logic [WAIT_W-1:0] max_wait
);
   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;
   localparam logic [1:0] BAD    = 2'b11;
   localparam int EL = 4;
   localparam int ES = 3;
   localparam int WL = 2;
   localparam int WS = 1;
   localparam int NS = 0;

   logic [1:0]        light  [5];
   logic [1:0]        prev   [5];
   logic [Q_W-1:0]    q      [5];
   logic [Q_W-1:0]    q_nxt  [5];
   logic [WAIT_W-1:0] wt     [5];
   logic [WAIT_W-1:0] wt_nxt [5];
   logic [4:0]        dep;
   logic [4:0]        nr;
   logic              ovf_hit;
   logic              seq_bad;
   logic              conflict;
   logic [SRV_W-1:0]  served_nxt;
   logic [WAIT_W-1:0] max_nxt;

   assign light[EL] = e_left_light;
   assign light[ES] = e_str_light;
   assign light[WL] = w_left_light;
   assign light[WS] = w_str_light;
   assign light[NS] = ns_light;

   assign nr = {e_left_light != RED, e_str_light != RED, w_left_light != RED,
                w_str_light != RED, ns_light != RED};

   // Opposing lefts and opposing straights may share a phase; every other crossing pair conflicts.
   assign conflict = (nr[EL] && (nr[WS] || nr[NS])) ||
                     (nr[WL] && (nr[ES] || nr[NS])) ||
                     ((nr[ES] || nr[WS]) && nr[NS]);

   always_comb begin
      dep        = '0;
      ovf_hit    = 1'b0;
      seq_bad    = 1'b0;
      served_nxt = served_cnt;
      max_nxt    = max_wait;
      for (int i = 0; i < 5; i++) begin
         q_nxt[i]  = q[i];
         wt_nxt[i] = wt[i];
         dep[i]    = (light[i] == GREEN) && (q[i] != '0);
         if (arrive[i] && !dep[i]) begin
            if (&q[i]) ovf_hit = 1'b1;
            else       q_nxt[i] = q[i] + Q_W'(1);
         end else if (dep[i] && !arrive[i]) begin
            q_nxt[i] = q[i] - Q_W'(1);
         end
         if (q[i] == '0 || light[i] == GREEN) wt_nxt[i] = '0;
         else if (!(&wt[i]))                  wt_nxt[i] = wt[i] + WAIT_W'(1);
         if (wt_nxt[i] > max_nxt) max_nxt = wt_nxt[i];
         if (light[i] == BAD || prev[i] == BAD) begin
            seq_bad = 1'b1;
         end else if (light[i] != prev[i] &&
                      !((prev[i] == RED    && light[i] == GREEN)  ||
                        (prev[i] == GREEN  && light[i] == YELLOW) ||
                        (prev[i] == YELLOW && light[i] == RED))) begin
            seq_bad = 1'b1;
         end
         served_nxt = served_nxt + SRV_W'(dep[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            q[i]    <= '0;
            wt[i]   <= '0;
            prev[i] <= RED;
         end
         conflict_err <= 1'b0;
         seq_err      <= 1'b0;
         ovf_err      <= 1'b0;
         served_cnt   <= '0;
         max_wait     <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            q[i]    <= q_nxt[i];
            wt[i]   <= wt_nxt[i];
            prev[i] <= light[i];
         end
         conflict_err <= conflict_err | conflict;
         seq_err      <= seq_err | seq_bad;
         ovf_err      <= ovf_err | ovf_hit;
         served_cnt   <= served_nxt;
         max_wait     <= max_nxt;
      end
   end

   assign e_left_sensor = (q[EL] != '0);
   assign e_str_sensor  = (q[ES] != '0);
   assign w_left_sensor = (q[WL] != '0);
   assign w_str_sensor  = (q[WS] != '0);
   assign ns_sensor     = (q[NS] != '0);
endmodule

// File: tb/tb_traffic_intersection_model.sv
// Bench for traffic_intersection_model: lane-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized legal and unconstrained light traffic.
module tb_traffic_intersection_model;
   localparam int Q_W    = 4;
   localparam int WAIT_W = 8;
   localparam int SRV_W  = 16;
   localparam int QMAX   = (1 << Q_W) - 1;
   localparam int WMAX   = (1 << WAIT_W) - 1;
   localparam int EL = 4, ES = 3, WL = 2, WS = 1, NS = 0;
   localparam logic [1:0] RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10, BAD = 2'b11;

   logic              clk = 1'b0;
   logic              reset;
   logic [4:0]        arrive;
   logic [1:0]        lt [5];
   logic              e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor;
   logic              conflict_err, seq_err, ovf_err;
   logic [SRV_W-1:0]  served_cnt;
   logic [WAIT_W-1:0] max_wait;
   logic [4:0]        sens;

   int checks   = 0;
   int failures = 0;

   int mq [5];
   int mw [5];
   int mprev [5];
   int mmax, mserv;
   bit mconf, mseq, movf;

   traffic_intersection_model #(.Q_W(Q_W), .WAIT_W(WAIT_W), .SRV_W(SRV_W)) dut (
      .clk(clk), .reset(reset), .arrive(arrive),
      .e_left_light(lt[EL]), .e_str_light(lt[ES]), .w_left_light(lt[WL]),
      .w_str_light(lt[WS]), .ns_light(lt[NS]),
      .e_left_sensor(e_left_sensor), .e_str_sensor(e_str_sensor),
      .w_left_sensor(w_left_sensor), .w_str_sensor(w_str_sensor), .ns_sensor(ns_sensor),
      .conflict_err(conflict_err), .seq_err(seq_err), .ovf_err(ovf_err),
      .served_cnt(served_cnt), .max_wait(max_wait)
   );

   assign sens = {e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_colour(input int c);
      case (c)
         0:       return 2;
         2:       return 1;
         1:       return 0;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         mq[i] = 0; mw[i] = 0; mprev[i] = 0;
      end
      mmax = 0; mserv = 0; mconf = 0; mseq = 0; movf = 0;
   endtask

   // One clock of the intersection: pairs of lanes whose paths cross, queues as plain integers.
   task automatic model_step();
      int ca [6] = '{EL, EL, WL, WL, ES, WS};
      int cb [6] = '{WS, NS, ES, NS, NS, NS};
      int cur, n, d;
      for (int p = 0; p < 6; p++)
         if (lt[ca[p]] != RED && lt[cb[p]] != RED) mconf = 1;
      for (int i = 0; i < 5; i++) begin
         cur = int'(lt[i]);
         if (cur == 3 || mprev[i] == 3) mseq = 1;
         else if (cur != mprev[i] && cur != next_colour(mprev[i])) mseq = 1;
         mprev[i] = cur;
         d = (cur == 2 && mq[i] > 0) ? 1 : 0;
         mw[i] = (mq[i] == 0 || cur == 2) ? 0 : ((mw[i] + 1 > WMAX) ? WMAX : mw[i] + 1);
         n = mq[i] + int'(arrive[i]) - d;
         if (n > QMAX) begin
            n = QMAX; movf = 1;
         end
         mq[i] = n;
         mserv = (mserv + d) % (1 << SRV_W);
         if (mw[i] > mmax) mmax = mw[i];
      end
   endtask

   always @(posedge clk) if (reset === 1'b1) model_step();

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         logic [4:0] es;
         for (int i = 0; i < 5; i++) es[i] = (mq[i] > 0);
         chk("sensors", 32'(sens), 32'(es));
         chk("conflict_err", 32'(conflict_err), 32'(mconf));
         chk("seq_err", 32'(seq_err), 32'(mseq));
         chk("ovf_err", 32'(ovf_err), 32'(movf));
         chk("served_cnt", 32'(served_cnt), 32'(mserv));
         chk("max_wait", 32'(max_wait), 32'(mmax));
      end
   end

   task automatic set_all(input logic [1:0] c);
      for (int i = 0; i < 5; i++) lt[i] = c;
   endtask

   task automatic do_reset();
      arrive = '0;
      set_all(RED);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic pulse(input int lane, input int n);
      for (int k = 0; k < n; k++) begin
         arrive = '0;
         arrive[lane] = 1'b1;
         @(negedge clk);
      end
      arrive = '0;
   endtask

   task automatic run_rand(input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 5; i++) arrive[i] = ($urandom_range(0, 9) < 3);
         @(negedge clk);
      end
      arrive = '0;
   endtask

   task automatic set_grp(input int g, input logic [1:0] c);
      case (g)
         0:       begin lt[EL] = c; lt[WL] = c; end
         1:       begin lt[ES] = c; lt[WS] = c; end
         default: lt[NS] = c;
      endcase
   endtask

   task automatic legal_phase(input int rounds);
      for (int r = 0; r < rounds; r++) begin
         set_grp(r % 3, GREEN);  run_rand($urandom_range(2, 8));
         set_grp(r % 3, YELLOW); run_rand($urandom_range(1, 2));
         set_grp(r % 3, RED);    run_rand($urandom_range(1, 3));
      end
   endtask

   task automatic wild_phase(input int n);
      int r;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 5; i++) begin
            r = $urandom_range(0, 15);
            lt[i] = (r < 9) ? RED : (r < 12) ? GREEN : (r < 15) ? YELLOW : BAD;
            arrive[i] = ($urandom_range(0, 9) < 3);
         end
         @(negedge clk);
      end
      arrive = '0;
   endtask

   initial begin
      reset = 1'b0;
      arrive = '0;
      set_all(RED);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset sensors", 32'(sens), 32'd0);
      chk("reset errors", 32'({conflict_err, seq_err, ovf_err}), 32'd0);
      chk("reset served", 32'(served_cnt), 32'd0);
      chk("reset max_wait", 32'(max_wait), 32'd0);

      pulse(NS, 1);
      chk("ns sensor after arrival", 32'(ns_sensor), 32'd1);
      chk("other sensors idle", 32'(sens), 32'b00001);

      // Queue drain and wait tracking on e_left.
      do_reset();
      pulse(EL, 3);
      repeat (8) @(negedge clk);
      chk("e_left wait 10", 32'(max_wait), 32'd10);
      lt[EL] = GREEN;
      repeat (2) @(negedge clk);
      chk("e_left sensor mid-drain", 32'(e_left_sensor), 32'd1);
      @(negedge clk);
      chk("e_left sensor drained", 32'(e_left_sensor), 32'd0);
      chk("served after drain", 32'(served_cnt), 32'd3);
      chk("max_wait sticky", 32'(max_wait), 32'd10);

      // Arrival and departure in the same cycle leave the queue unchanged.
      do_reset();
      pulse(WS, 2);
      lt[WS] = GREEN;
      pulse(WS, 4);
      chk("w_str served 4", 32'(served_cnt), 32'd4);
      chk("w_str sensor held", 32'(w_str_sensor), 32'd1);
      repeat (2) @(negedge clk);
      chk("w_str drained", 32'(served_cnt), 32'd6);
      lt[WS] = YELLOW; @(negedge clk);
      lt[WS] = RED;    @(negedge clk);

      // Overflow.
      do_reset();
      pulse(NS, 15);
      chk("ovf before full", 32'(ovf_err), 32'd0);
      pulse(NS, 1);
      chk("ovf after 16th", 32'(ovf_err), 32'd1);
      chk("ns sensor at full", 32'(ns_sensor), 32'd1);

      // Conflicts.
      do_reset();
      lt[EL] = GREEN; lt[NS] = GREEN;
      @(negedge clk);
      chk("conflict e_left+ns", 32'(conflict_err), 32'd1);
      do_reset();
      lt[EL] = GREEN; lt[WL] = GREEN;
      repeat (3) @(negedge clk);
      chk("no conflict lefts", 32'(conflict_err), 32'd0);

      // Colour sequences.
      do_reset();
      lt[ES] = GREEN; repeat (2) @(negedge clk);
      chk("seq ok red->green", 32'(seq_err), 32'd0);
      lt[ES] = RED; @(negedge clk);
      chk("seq green->red", 32'(seq_err), 32'd1);
      do_reset();
      lt[ES] = GREEN;  repeat (2) @(negedge clk);
      lt[ES] = YELLOW; repeat (2) @(negedge clk);
      lt[ES] = RED;    repeat (2) @(negedge clk);
      chk("seq legal cycle", 32'(seq_err), 32'd0);
      do_reset();
      lt[NS] = BAD; @(negedge clk);
      chk("seq illegal code", 32'(seq_err), 32'd1);
      chk("no conflict lone ns", 32'(conflict_err), 32'd0);

      // Wait counter saturation.
      do_reset();
      pulse(NS, 1);
      repeat (300) @(negedge clk);
      chk("max_wait saturates", 32'(max_wait), 32'(WMAX));

      do_reset();
      legal_phase(60);
      chk("legal phase clean", 32'({conflict_err, seq_err}), 32'd0);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async served", 32'(served_cnt), 32'd0);
      chk("async sensors", 32'(sens), 32'd0);
      chk("async max_wait", 32'(max_wait), 32'd0);
      model_reset();
      arrive = '0;
      set_all(RED);
      @(negedge clk);
      reset = 1'b1;

      wild_phase(300);
      do_reset();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
